// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, strobe decode and LFSR seed for the BIST controller
package bist_pkg;

    localparam int          SIG_W_DEFAULT = 16;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic bist_mode;
        logic lfsr_load;
        logic lfsr_en;
        logic misr_clr;
        logic misr_en;
        logic cut_rst;
        logic bist_end;
    } strobes_t;

    function automatic strobes_t decode_strobes(state_t s);
        strobes_t o;
        o = '0;
        case (s)
            S_INIT: begin
                o.bist_mode = 1'b1;
                o.lfsr_load = 1'b1;
                o.misr_clr  = 1'b1;
                o.cut_rst   = 1'b1;
            end
            S_RUN: begin
                o.bist_mode = 1'b1;
                o.lfsr_en   = 1'b1;
                o.misr_en   = 1'b1;
            end
            S_COMPARE: o.bist_mode = 1'b1;
            S_DONE:    o.bist_end  = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bist_if.sv
// rtl/bist_if.sv - start/result and LFSR/MISR/CUT control bundle of the BIST controller
interface bist_if #(
    parameter int SIG_W = 16
);
    logic             bist_start;
    logic [SIG_W-1:0] misr_sig;
    logic             bist_mode;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_clr;
    logic             misr_en;
    logic             cut_rst;
    logic             bist_end;
    logic             pass_fail;

    modport master (
        input  bist_start, misr_sig,
        output bist_mode, lfsr_load, lfsr_en, misr_clr, misr_en, cut_rst, bist_end, pass_fail
    );

    modport slave (
        output bist_start, misr_sig,
        input  bist_mode, lfsr_load, lfsr_en, misr_clr, misr_en, cut_rst, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_cycle_counter.sv
// rtl/bist_cycle_counter.sv - phase-length counter with clear, enable and terminal-count compare
module bist_cycle_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Equality exit: the counter never needs to wrap within a phase.
    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - sequences seed/clear/reset, pattern application and signature compare
module bist_controller
    import bist_pkg::*;
#(
    parameter int               N_PATTERNS     = 1000,
    parameter int               CNT_W          = 10,
    parameter int               SIG_W          = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0] GOLDEN_SIG     = '0,
    parameter int               CUT_RST_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    bist_if.master bus
);
    if (N_PATTERNS < 1) begin : g_chk_np
        $error("N_PATTERNS must be >= 1");
    end
    if (CUT_RST_CYCLES < 1) begin : g_chk_rst
        $error("CUT_RST_CYCLES must be >= 1");
    end
    if (((N_PATTERNS - 1) >> CNT_W) != 0 || ((CUT_RST_CYCLES - 1) >> CNT_W) != 0) begin : g_chk_w
        $error("CNT_W too narrow for phase lengths");
    end

    state_t     state_q, state_d;
    strobes_t   strobes_q;
    logic       start_q;
    logic       pass_fail_q;
    logic       start_pulse;
    logic       cnt_en, cnt_clr, cnt_tc;
    logic [CNT_W-1:0] cnt_term;

    assign start_pulse = bus.bist_start & ~start_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_pulse) state_d = S_INIT;
            S_INIT:    if (cnt_tc)      state_d = S_RUN;
            S_RUN:     if (cnt_tc)      state_d = S_COMPARE;
            S_COMPARE:                  state_d = S_DONE;
            S_DONE:    if (start_pulse) state_d = S_INIT;
            default:                    state_d = S_IDLE;
        endcase
    end

    // One counter times both INIT and RUN; it restarts from 0 on every state change.
    assign cnt_en   = (state_q == S_INIT) || (state_q == S_RUN);
    assign cnt_clr  = (state_d != state_q) || !cnt_en;
    assign cnt_term = (state_q == S_INIT) ? CNT_W'(CUT_RST_CYCLES - 1) : CNT_W'(N_PATTERNS - 1);

    bist_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    // start_q resets to 1 so a start held high across reset needs a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b1;
            strobes_q   <= '0;
            pass_fail_q <= 1'b0;
        end else begin
            start_q   <= bus.bist_start;
            state_q   <= state_d;
            strobes_q <= decode_strobes(state_d);
            if (state_q == S_COMPARE) begin
                pass_fail_q <= (bus.misr_sig == GOLDEN_SIG);
            end
        end
    end

    assign bus.bist_mode = strobes_q.bist_mode;
    assign bus.lfsr_load = strobes_q.lfsr_load;
    assign bus.lfsr_en   = strobes_q.lfsr_en;
    assign bus.misr_clr  = strobes_q.misr_clr;
    assign bus.misr_en   = strobes_q.misr_en;
    assign bus.cut_rst   = strobes_q.cut_rst;
    assign bus.bist_end  = strobes_q.bist_end;
    assign bus.pass_fail = pass_fail_q;

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - randomized self-checking bench for bist_controller
module tb_bist_controller;
    localparam int          NP   = 8;
    localparam int          CR   = 2;
    localparam logic [15:0] GOLD = 16'hBEEF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic prev_pf;

    bist_if #(.SIG_W(16)) bus ();

    bist_controller #(
        .N_PATTERNS     (NP),
        .CNT_W          (10),
        .SIG_W          (16),
        .GOLDEN_SIG     (GOLD),
        .CUT_RST_CYCLES (CR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observed();
        return {bus.bist_mode, bus.lfsr_load, bus.lfsr_en, bus.misr_clr,
                bus.misr_en, bus.cut_rst, bus.bist_end, bus.pass_fail};
    endfunction

    // k counts sampling points after the edge that saw the start rising edge.
    function automatic logic [7:0] expected(int k, logic pf);
        logic init_p, run_p, cmp_p, done_p;
        init_p = (k >= 1) && (k <= CR);
        run_p  = (k > CR) && (k <= CR + NP);
        cmp_p  = (k == CR + NP + 1);
        done_p = (k > CR + NP + 1);
        return {init_p | run_p | cmp_p, init_p, run_p, init_p, run_p, init_p, done_p, pf};
    endfunction

    task automatic run_scenario(input string name, input logic [15:0] sig,
                                input int toggle_k, input int abort_k);
        int       en_cnt;
        logic     pf_now;
        logic [7:0] exp_v;
        en_cnt = 0;
        bus.bist_start = 1'b0;
        bus.misr_sig   = sig;
        @(negedge clk);
        bus.bist_start = 1'b1;
        for (int k = 1; k <= CR + NP + 3; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                n_checks++;
                if (observed() !== 8'h00) begin
                    n_fail++;
                    $display("FAIL %s abort: outputs=%b required=%b", name, observed(), 8'h00);
                end
                prev_pf = 1'b0;
                bus.bist_start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            pf_now = (k > CR + NP + 1) ? (sig == GOLD) : prev_pf;
            exp_v  = expected(k, pf_now);
            n_checks++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs=%b required=%b", name, k, observed(), exp_v);
            end
            if (bus.lfsr_en === 1'b1) en_cnt++;
            if (k == toggle_k)     bus.bist_start = 1'b0;
            if (k == toggle_k + 1) bus.bist_start = 1'b1;
        end
        prev_pf = (sig == GOLD);
        n_checks++;
        if (en_cnt !== NP) begin
            n_fail++;
            $display("FAIL %s lfsr_en count: got %0d required %0d", name, en_cnt, NP);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.bist_start = 1'b0;
        bus.misr_sig   = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_pf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (observed() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset idle %0d: outputs=%b required=%b", i, observed(), 8'h00);
            end
        end
    endtask

    task automatic test_pass_fail();
        run_scenario("pass", GOLD, -10, -10);
        run_scenario("fail", 16'hBEEE, -10, -10);
        run_scenario("rerun_pass", GOLD, -10, -10);
    endtask

    task automatic test_start_through_reset();
        rst = 1'b1;
        bus.bist_start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_pf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (observed() !== 8'h00) begin
                n_fail++;
                $display("FAIL held_start %0d: outputs=%b required=%b", i, observed(), 8'h00);
            end
        end
        run_scenario("after_held_start", GOLD, -10, -10);
    endtask

    task automatic test_toggle_mid_run();
        run_scenario("toggle_run4", GOLD, CR + 4, -10);
    endtask

    task automatic test_abort();
        run_scenario("abort_run5", GOLD, -10, CR + 5);
        run_scenario("after_abort", 16'h1234, -10, -10);
    endtask

    task automatic test_random();
        logic [15:0] sig;
        int          tog;
        for (int r = 0; r < 8; r++) begin
            sig = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom());
            tog = $urandom_range(1, CR + NP);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_scenario($sformatf("random%0d", r), sig, tog, -10);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_pf  = 1'b0;
        rst      = 1'b1;
        bus.bist_start = 1'b0;
        bus.misr_sig   = 16'h0000;
        test_reset();
        test_pass_fail();
        test_start_through_reset();
        test_toggle_mid_run();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
